// File: rtl/serial_sched_pkg.sv
// Shared types for the serial round-robin scheduler.
// The FSM states live here so other blocks and benches can decode them.
package serial_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_rr_sched_rr_pick.sv
// Combinational rotating-priority picker: first set req bit after last_ptr, modulo N_REQ.
// No state; handles non-power-of-2 N_REQ by explicit wrap subtraction.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   int               cand;
   logic [IDX_W-1:0] cidx;

   always_comb begin
      any    = 1'b0;
      idx    = '0;
      onehot = '0;
      cand   = 0;
      cidx   = '0;
      // Offset 1..N_REQ from the last winner, so the last winner is checked last.
      for (int k = 1; k <= N_REQ; k++) begin
         cand = int'(last_ptr) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         cidx = cand[IDX_W-1:0];
         if (!any && req[cidx]) begin
            any = 1'b1;
            idx = cidx;
         end
      end
      if (any) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/serial_rr_sched.sv
// Round-robin scheduler sharing one bit-serial channel; frames go out LSB-first.
// Grant one cycle after a request is seen in IDLE; ser_ready low stalls the shift in place.
module serial_rr_sched
   import serial_sched_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int FRAME_LEN = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req,
   input  logic [N_REQ*FRAME_LEN-1:0]   frame,
   output logic [N_REQ-1:0]             gnt,
   output logic [N_REQ-1:0]             done,
   output logic                         ser_out,
   output logic                         ser_valid,
   input  logic                         ser_ready,
   output logic                         busy
);

   localparam int PW = $clog2(N_REQ);
   localparam int CW = $clog2(FRAME_LEN);

   state_t                 state;
   state_t                 state_nxt;
   logic [PW-1:0]          last_ptr;
   logic [PW-1:0]          win_idx;
   logic [FRAME_LEN-1:0]   shreg;
   logic [CW-1:0]          count;
   logic [N_REQ-1:0]       gnt_r;
   logic                   last_bit;

   logic                   pick_any;
   logic [PW-1:0]          pick_idx;
   logic [N_REQ-1:0]       pick_onehot;
   logic [FRAME_LEN-1:0]   frames [N_REQ];

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         frames[i] = frame[i*FRAME_LEN +: FRAME_LEN];
      end
   end

   rr_pick #(.N_REQ(N_REQ), .IDX_W(PW)) u_pick (
      .req      (req),
      .last_ptr (last_ptr),
      .any      (pick_any),
      .idx      (pick_idx),
      .onehot   (pick_onehot)
   );

   assign last_bit = (count == CW'(FRAME_LEN - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_any) state_nxt = SEND;
         SEND:    if (ser_ready && last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last_ptr <= PW'(N_REQ - 1);
         win_idx  <= '0;
         shreg    <= '0;
         count    <= '0;
         gnt_r    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  shreg   <= frames[pick_idx];
                  gnt_r   <= pick_onehot;
                  win_idx <= pick_idx;
                  count   <= '0;
               end
            end
            SEND: begin
               if (ser_ready) begin
                  shreg <= shreg >> 1;
                  // Wrap to zero on the last bit so count never reaches FRAME_LEN.
                  count <= last_bit ? '0 : count + 1'b1;
               end
            end
            DONE: begin
               last_ptr <= win_idx;
               gnt_r    <= '0;
            end
            default: ;
         endcase
      end
   end

   assign gnt       = gnt_r;
   assign done      = (state == DONE) ? gnt_r : '0;
   assign ser_valid = (state == SEND);
   assign ser_out   = (state == SEND) & shreg[0];
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_rr_sched.sv
// Bench for serial_rr_sched: vector table, directed corner sequences, random traffic
// against a transaction-level model, and a 3-requester instance for pointer wrap.
module tb_serial_rr_sched;

   localparam int N = 4;
   localparam int F = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [N-1:0]     req;
   logic [N*F-1:0]   frame;
   logic             ser_ready;
   logic [N-1:0]     gnt, done;
   logic             ser_out, ser_valid, busy;

   logic             rst3;
   logic [2:0]       req3;
   logic [3*F-1:0]   frame3;
   logic             ready3;
   logic [2:0]       gnt3, done3;
   logic             so3, sv3, busy3;

   serial_rr_sched #(.N_REQ(N), .FRAME_LEN(F)) dut (
      .clk(clk), .rst(rst), .req(req), .frame(frame), .gnt(gnt), .done(done),
      .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready), .busy(busy)
   );

   serial_rr_sched #(.N_REQ(3), .FRAME_LEN(F)) dut3 (
      .clk(clk), .rst(rst3), .req(req3), .frame(frame3), .gnt(gnt3), .done(done3),
      .ser_out(so3), .ser_valid(sv3), .ser_ready(ready3), .busy(busy3)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Model: who holds the channel, which bits remain, and whether done is due.
   bit   m_known = 1'b0;
   int   m_win   = -1;
   int   m_last  = N - 1;
   bit   m_bits[$];
   bit   m_donep = 1'b0;

   int   grants[$];
   int   dones[$];
   bit   accepted[$];
   logic [N-1:0] prev_gnt = '0;

   function automatic int first_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i] === 1'b1) return i;
      return -1;
   endfunction

   task automatic obs();
      logic [N-1:0] eg;
      logic [N-1:0] ed;
      @(negedge clk);
      eg = '0;
      if (m_win >= 0) eg[m_win] = 1'b1;
      ed = m_donep ? eg : '0;
      if (m_known) begin
         check("model_outputs", {19'd0, busy, ser_valid, ser_out, done, gnt},
               {19'd0, (m_win >= 0), (m_bits.size() > 0),
                (m_bits.size() > 0) ? m_bits[0] : 1'b0, ed, eg});
      end
      if (gnt !== '0 && gnt !== 'x && prev_gnt === '0) grants.push_back(first_idx(gnt));
      if (done !== '0 && done !== 'x) dones.push_back(first_idx(done));
      prev_gnt = gnt;
   endtask

   task automatic drv(input logic r, input logic [N-1:0] q, input logic [N*F-1:0] fr,
                      input logic rdy);
      if (ser_valid === 1'b1 && rdy) accepted.push_back(ser_out);
      rst = r; req = q; frame = fr; ser_ready = rdy;
      if (r) begin
         m_known = 1'b1; m_win = -1; m_last = N - 1; m_bits.delete(); m_donep = 1'b0;
      end else if (!m_known) begin
      end else if (m_donep) begin
         m_last = m_win; m_win = -1; m_donep = 1'b0;
      end else if (m_win >= 0) begin
         if (rdy) begin
            void'(m_bits.pop_front());
            if (m_bits.size() == 0) m_donep = 1'b1;
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (q[c]) begin
               m_win = c;
               for (int b = 0; b < F; b++) m_bits.push_back(fr[c*F + b]);
               break;
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic [N-1:0] q, input logic [N*F-1:0] fr,
                       input logic rdy);
      obs();
      drv(r, q, fr, rdy);
   endtask

   task automatic clear_obs();
      grants.delete(); dones.delete(); accepted.delete();
   endtask

   task automatic check_q(input string name, input int q[$], input int i, input int exp);
      check(name, (i < q.size()) ? q[i] : -1, exp);
   endtask

   typedef struct {
      logic         r;
      logic [N-1:0] q;
      logic [7:0]   f0;
      bit           chk;
      logic [N-1:0] eg, ed;
      logic         eo, ev, eb;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [7:0] a5;
      logic [7:0] c3;
      int         gi;
      rst = 1'b1; req = '0; frame = '0; ser_ready = 1'b1;
      rst3 = 1'b1; req3 = '0; frame3 = '0; ready3 = 1'b1;

      // Reset, request requester 0 with A5; outputs listed are those seen in that cycle.
      a5 = 8'hA5;
      tbl[0]  = '{1'b1, 4'b0000, 8'hA5, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 4'b0001, 8'hA5, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++)
         tbl[2+i] = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b0001, 4'b0000, a5[i], 1'b1, 1'b1};
      tbl[10] = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 12; i++) begin
         obs();
         if (tbl[i].chk) begin
            check($sformatf("vec%0d", i), {27'd0, busy, ser_valid, ser_out, gnt[0], done[0]},
                  {27'd0, tbl[i].eb, tbl[i].ev, tbl[i].eo, tbl[i].eg[0], tbl[i].ed[0]});
            check($sformatf("vec%0d_vec", i), {24'd0, gnt, done}, {24'd0, tbl[i].eg, tbl[i].ed});
         end
         drv(tbl[i].r, tbl[i].q, {24'd0, tbl[i].f0}, 1'b1);
      end

      // All requesters held: strict rotation starting at 0.
      step(1'b1, '0, '0, 1'b1); clear_obs();
      repeat (60) step(1'b0, 4'hF, {$urandom, $urandom}, 1'b1);
      for (int i = 0; i < 5; i++) check_q("all_req_grant", grants, i, i % 4);
      for (int i = 0; i < 4; i++) check_q("all_req_done", dones, i, i);

      // Requesters 0 and 2: eight ones then eight zeros.
      step(1'b1, '0, '0, 1'b1); clear_obs();
      repeat (24) step(1'b0, 4'b0101, {8'h00, 8'h00, 8'h00, 8'hFF}, 1'b1);
      for (int i = 0; i < 16; i++)
         check("bits_0_2", (i < accepted.size()) ? accepted[i] : 1'bx, (i < 8));
      check_q("done_0_2_first", dones, 0, 0);
      check_q("done_0_2_second", dones, 1, 2);

      // Stall pattern 1,0,0,1 repeating during 3C.
      c3 = 8'h3C;
      step(1'b1, '0, '0, 1'b1); clear_obs();
      step(1'b0, 4'b0001, {24'd0, 8'h3C}, 1'b1);
      for (int i = 0; i < 40; i++) step(1'b0, '0, '0, (i % 4 == 0) || (i % 4 == 3));
      check("stall_nbits", accepted.size(), 8);
      for (int i = 0; i < 8; i++)
         check("stall_bits", (i < accepted.size()) ? accepted[i] : 1'bx, c3[i]);
      check("stall_ndone", dones.size(), 1);

      // Request dropped at bit 3 still completes.
      step(1'b1, '0, '0, 1'b1); clear_obs();
      step(1'b0, 4'b0001, {24'd0, 8'h5A}, 1'b1);
      repeat (3) step(1'b0, 4'b0001, '0, 1'b1);
      repeat (12) step(1'b0, 4'b0000, '0, 1'b1);
      check("drop_ndone", dones.size(), 1);
      check("drop_nbits", accepted.size(), 8);

      // Reset mid-frame drops the frame without done; then 0 beats 3.
      step(1'b1, '0, '0, 1'b1); clear_obs();
      step(1'b0, 4'b1000, {8'hC3, 24'd0}, 1'b1);
      repeat (5) step(1'b0, 4'b1000, '0, 1'b1);
      step(1'b1, 4'b1000, '0, 1'b1);
      obs();
      check("mid_rst_idle", {29'd0, gnt != '0, ser_valid, busy}, 32'd0);
      drv(1'b0, '0, '0, 1'b1);
      repeat (10) step(1'b0, '0, '0, 1'b1);
      check("mid_rst_ndone", dones.size(), 0);
      step(1'b0, 4'b1001, '0, 1'b1);
      obs();
      check("post_rst_prio", gnt, 4'b0001);
      drv(1'b0, '0, '0, 1'b1);

      // Random traffic against the model.
      for (int i = 0; i < 500; i++)
         step(($urandom_range(0, 79) == 0), N'($urandom), {$urandom, $urandom},
              ($urandom_range(0, 3) != 0));

      // Three-requester instance: modulo wrap of the pointer.
      @(negedge clk); rst3 = 1'b0; req3 = 3'b111; frame3 = 24'h5A_C3_96;
      gi = 0;
      begin
         logic [2:0] p3;
         int order3[$];
         p3 = '0;
         for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (gnt3 != '0 && p3 == '0) order3.push_back(gnt3 == 3'b001 ? 0 : gnt3 == 3'b010 ? 1 :
                                                         gnt3 == 3'b100 ? 2 : -1);
            p3 = gnt3;
         end
         for (int i = 0; i < 5; i++) check_q("wrap3_grant", order3, i, i % 3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
